sp_ram_master: RTL

Initiator-side controller for the single-port 32K x 8 block-RAM macro: it turns a valid/ready command stream (read/write) into registered CE/WRE/AD/DIN strobes on the RAM pins and returns read data through a credit-limited response FIFO. It also contains a clear engine that fills the whole array with one byte value. It sits between platform bus logic and the RAM wrapper. No other block drives the RAM.

---
 rtl/sp_ram_master_if.sv | 25 ++
 rtl/sp_ram_master.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_master_if.sv
// Command/response stream between platform bus logic and sp_ram_master.
// The platform side is the master; the RAM controller is the slave.
interface sp_ram_master_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sp_ram_master.sv
// Initiator for a single-port block RAM: registered command strobes, a
// credit-limited in-order read response FIFO, and a whole-array clear engine.
module sp_ram_master #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1,
  parameter int RSP_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  sp_ram_master_if.slave    bus,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              busy,
  output logic              ram_ce,
  output logic              ram_wre,
  output logic              ram_oce,
  output logic              ram_reset,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CRD_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 2)
      $error("sp_ram_master: READ_LATENCY must be 1 or 2");
    if (RSP_DEPTH < READ_LATENCY + 2)
      $error("sp_ram_master: RSP_DEPTH must be at least READ_LATENCY+2");
  endgenerate

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t            state, state_nxt;
  logic [CRD_W-1:0]  credit;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_data;
  logic [READ_LATENCY-1:0] rd_tag;

  logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CRD_W-1:0]  fifo_cnt;

  logic              cmd_fire, rd_fire, rsp_push, rsp_pop, clr_go;
  logic              stb_ce, stb_we;
  logic [ADDR_W-1:0] stb_ad;
  logic [DATA_W-1:0] stb_din;

  assign bus.cmd_ready = !reset && (state == ST_IDLE) && !clr_start &&
                         (bus.cmd_we || credit < CRD_MAX);
  assign cmd_fire  = bus.cmd_valid && bus.cmd_ready;
  assign rd_fire   = cmd_fire && !bus.cmd_we;
  assign clr_go    = (state == ST_IDLE) && clr_start;
  assign rsp_pop   = bus.rsp_valid && bus.rsp_ready;
  assign rsp_push  = rd_tag[READ_LATENCY-1];
  assign busy      = (state == ST_CLEAR);
  assign ram_oce   = 1'b1;
  assign ram_reset = reset;

  // The first clear strobe (address 0) is issued on entry, so clr_addr holds
  // the next address to write; its wrap back to 0 marks the end of the fill.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    state_nxt = state;
    stb_ce    = 1'b0;
    stb_we    = 1'b0;
    stb_ad    = ram_ad;
    stb_din   = ram_din;
    case (state)
      ST_IDLE: begin
        if (clr_start) begin
          state_nxt = ST_CLEAR;
          stb_ce    = 1'b1;
          stb_we    = 1'b1;
          stb_ad    = '0;
          stb_din   = clr_value;
        end else if (cmd_fire) begin
          stb_ce  = 1'b1;
          stb_we  = bus.cmd_we;
          stb_ad  = bus.cmd_addr;
          stb_din = bus.cmd_wdata;
        end
      end
      ST_CLEAR: begin
        if (clr_addr == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          stb_ce  = 1'b1;
          stb_we  = 1'b1;
          stb_ad  = clr_addr;
          stb_din = clr_data;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_addr <= '0;
      clr_data <= '0;
    end else if (clr_go) begin
      clr_addr <= ADDR_W'(1);
      clr_data <= clr_value;
    end else if (busy && clr_addr != '0) begin
      clr_addr <= clr_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_ce  <= 1'b0;
      ram_wre <= 1'b0;
      ram_ad  <= '0;
      ram_din <= '0;
    end else begin
      ram_ce  <= stb_ce;
      ram_wre <= stb_we;
      ram_ad  <= stb_ad;
      ram_din <= stb_din;
    end
  end

  // rd_tag[i] is set while a read strobed i+1 cycles ago is in the RAM pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_tag <= '0;
    end else begin
      rd_tag[0] <= ram_ce && !ram_wre;
      for (int i = 1; i < READ_LATENCY; i++) rd_tag[i] <= rd_tag[i-1];
    end
  end

  // Credit counts reads in flight plus buffered, bounding FIFO occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      credit <= '0;
    end else begin
      case ({rd_fire, rsp_pop})
        2'b10:   credit <= credit + CRD_W'(1);
        2'b01:   credit <= credit - CRD_W'(1);
        default: credit <= credit;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (rsp_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (rsp_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      case ({rsp_push, rsp_pop})
        2'b10:   fifo_cnt <= fifo_cnt + CRD_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CRD_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; fifo_cnt alone decides
  // whether the head entry is meaningful.
  always_ff @(posedge clk) begin
    if (rsp_push) fifo_mem[wr_ptr] <= ram_dout;
  end

  assign bus.rsp_valid = (fifo_cnt != '0);
  assign bus.rsp_rdata = fifo_mem[rd_ptr];

endmodule
